uart_frame_arbiter: RTL and testbench
=====================================

# uart_frame_arbiter

Shares the single serial transmitter (TxD_start / TxD_data / TxD_busy) between two frame producers: the Campbell power result (2 × 24-bit) and the pulse-counter result (2 × 16-bit). It replaces fixed-delay byte pacing with a busy handshake and round-robin arbitration. Each granted frame is sent as a header byte, the payload bytes MSB first, and a 0xFF terminator, with a programmable idle gap after every byte.

## Interface
- GAP_CYCLES, 16'd200: idle clk cycles after TxD_busy falls before the next TxD_start or frame end; 16-bit.
- BUSY_TO, 16'd1000: cycles allowed for synchronized TxD_busy to rise after TxD_start; 16-bit.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  channel 0 (Campbell) frame request; level, held until ack0
- data0  in  48  channel 0 payload {power1[23:0], power2[23:0]}
- ack0  out  1  one-cycle pulse; data0 captured this cycle
- req1  in  1  channel 1 (pulse counts) frame request; level, held until ack1
- data1  in  32  channel 1 payload {count1[15:0], count2[15:0]}
- ack1  out  1  one-cycle pulse; data1 captured this cycle
- TxD_start  out  1  one-cycle byte-start strobe to transmitter
- TxD_data  out  8  byte to transmit; valid with TxD_start, held until next TxD_start
- TxD_busy  in  1  transmitter busy (asynchronous to this FSM; 2-flop synchronized internally)
- frame_active  out  1  high from LATCH through the terminator's gap
- grant  out  1  channel currently or last served
- err_timeout  out  1  sticky; set when a busy timeout occurs, cleared only by rst

## Operation
- Reset values: state IDLE, TxD_start 0, TxD_data 8'h00, ack0/ack1 0, frame_active 0, grant 1, err_timeout 0, busy synchronizer 0, all counters 0.
- FSM states: IDLE, LATCH, SEND, WAIT_HI, WAIT_LO, GAP.
- IDLE: if any req is high, select a channel and go to LATCH. If only one req is high, select that channel. If both are high, select the channel != grant (round-robin). After reset, grant is 1, so channel 0 wins the first tie.
- LATCH (1 cycle):
  - Pulse ack of the selected channel and update grant.
  - Copy the payload into a 48-bit shift register, left-aligned. Channel 1 is zero-padded in the low 16 bits.
  - Set byte count: channel 0 = 8 bytes, channel 1 = 6 bytes (header + payload + terminator).
  - Set byte index to 0 and frame_active to 1.
- SEND (1 cycle): TxD_start = 1. TxD_data is chosen by byte index:
  - index 0: {4'hA, 3'b000, grant}, i.e. 0xA0 or 0xA1.
  - last index: 8'hFF.
  - otherwise: the shift register's top byte, then shift left by 8.
  - Go to WAIT_HI.
- WAIT_HI: wait for synchronized busy = 1, then go to WAIT_LO. If BUSY_TO cycles elapse first, set err_timeout and go to GAP (byte treated as sent).
- WAIT_LO: wait for synchronized busy = 0, then go to GAP. There is no timeout here; busy stuck high stalls the FSM.
- GAP: count GAP_CYCLES, then increment byte index.
  - If index was the last: go to IDLE and set frame_active to 0 on the transition.
  - Otherwise: go to SEND.
- Requests are sampled only in IDLE. A req dropped before its ack is withdrawn without error. A req held high after its ack is treated as a new request on the next IDLE.
- Input data changes after ack have no effect on the frame in progress.

## Timing
- req sampled high in IDLE at cycle n: ack at n+1 (LATCH), first TxD_start at n+2.
- TxD_start is never high in two consecutive cycles.
- Minimum distance from a TxD_start to the next one: 2 (sync) + 1 + GAP_CYCLES + 1 cycles.
- After the last byte's GAP, IDLE is reached and the next frame's ack can come 1 cycle later. A waiting requester therefore waits at most one full frame.
- WAIT_HI timeout counter: clears in SEND, compares at BUSY_TO. The GAP counter clears on entry to GAP.
- Simultaneous req0 and req1 rising in the same IDLE cycle: only one ack is pulsed; the other channel is served immediately after the current frame.
- Async rst mid-frame: all outputs take their reset values at once; no ack and no partial byte are issued afterward; err_timeout clears.

## Test plan
- Single frame, channel 0: req0 with data0 = 48'h123456_ABCDEF; UART model raises busy 3 cycles after start and holds it 20 cycles. Required: bytes A0 12 34 56 AB CD EF FF, ack0 pulses once, frame_active drops after the last gap.
- Single frame, channel 1: req1 with data1 = 32'h0102_FFFE. Required: bytes A1 01 02 FF FE FF.
- Simultaneous req0 and req1 after reset, both held until ack. Required: the full channel 0 frame, then the full channel 1 frame. With both held high continuously, frames alternate 0, 1, 0, 1.
- Busy never asserts, BUSY_TO = 16. Required: err_timeout rises 16 cycles after the first TxD_start and stays high; all 8 bytes are still issued, each separated by 16 + GAP_CYCLES + 1 cycles.
- GAP_CYCLES = 5: measure from busy falling to the next TxD_start. Required: exactly 2 + 5 + 1 cycles, consistently across all bytes.
- rst asserted during byte 3 of a channel 0 frame. Required: TxD_start 0, TxD_data 00, frame_active 0 immediately; after release, the held req0 restarts a complete frame from header A0.

Source files
------------

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one byte-serial transmitter between the Campbell
// (2x24-bit) and pulse-count (2x16-bit) producers; frames are A0/A1, payload MSB first, FF.
module uart_frame_arbiter #(
    parameter logic [15:0] GAP_CYCLES = 16'd200,
    parameter logic [15:0] BUSY_TO    = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [47:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        ack1,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    input  logic        TxD_busy,
    output logic        frame_active,
    output logic        grant,
    output logic        err_timeout
);

    localparam int unsigned SHIFT_W = 48;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t               state, state_d;
    logic                 busy_s1, busy_s2;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d, last_q, last_d;
    logic [CNT_W-1:0]     to_cnt, to_cnt_d, gap_cnt, gap_cnt_d;
    logic                 ack0_d, ack1_d, start_d, fa_d, grant_d, err_d;
    logic [7:0]           data_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy_s1      <= 1'b0;
            busy_s2      <= 1'b0;
            shift_q      <= '0;
            idx_q        <= '0;
            last_q       <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            TxD_start    <= 1'b0;
            TxD_data     <= 8'h00;
            frame_active <= 1'b0;
            grant        <= 1'b1;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_d;
            busy_s1      <= TxD_busy;
            busy_s2      <= busy_s1;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            to_cnt       <= to_cnt_d;
            gap_cnt      <= gap_cnt_d;
            ack0         <= ack0_d;
            ack1         <= ack1_d;
            TxD_start    <= start_d;
            TxD_data     <= data_d;
            frame_active <= fa_d;
            grant        <= grant_d;
            err_timeout  <= err_d;
        end
    end

    // Next-state and next-output logic; outputs land one cycle later
    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        idx_d     = idx_q;
        last_d    = last_q;
        to_cnt_d  = to_cnt;
        gap_cnt_d = gap_cnt;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        start_d   = 1'b0;
        data_d    = TxD_data;
        fa_d      = frame_active;
        grant_d   = grant;
        err_d     = err_timeout;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the channel not served last wins
                    grant_d = (req0 && req1) ? ~grant : req1;
                    ack0_d  = ~grant_d;
                    ack1_d  = grant_d;
                    fa_d    = 1'b1;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                shift_d  = grant ? {data1, 16'h0000} : data0;
                last_d   = grant ? IDX_W'(5) : IDX_W'(7);
                idx_d    = '0;
                to_cnt_d = '0;
                start_d  = 1'b1;
                data_d   = {4'hA, 3'b000, grant};
                state_d  = SEND;
            end
            SEND: begin
                to_cnt_d = '0;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (busy_s2) begin
                    state_d = WAIT_LO;
                end else if (({1'b0, to_cnt} + 17'd1) >= {1'b0, BUSY_TO}) begin
                    // Transmitter never acknowledged: flag it and move on
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    to_cnt_d = to_cnt + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!busy_s2) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES}) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == last_q) begin
                        fa_d    = 1'b0;
                        state_d = IDLE;
                    end else begin
                        start_d  = 1'b1;
                        to_cnt_d = '0;
                        state_d  = SEND;
                        if ((idx_q + IDX_W'(1)) == last_q) begin
                            data_d = 8'hFF;
                        end else begin
                            data_d  = shift_q[SHIFT_W-1 -: 8];
                            shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
                        end
                    end
                end else begin
                    gap_cnt_d = gap_cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter with a simple transmitter busy model.
module tb_uart_frame_arbiter;

    localparam int G  = 5;
    localparam int BT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, ack0, ack1;
    logic [47:0] data0;
    logic [31:0] data1;
    logic        TxD_start, TxD_busy, frame_active, grant, err_timeout;
    logic [7:0]  TxD_data;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int uart_mode = 0;     // 0: busy 3 cycles after start for 20 cycles, 1: never busy
    int last_fall = 0;
    logic [7:0] exp_q[$];

    uart_frame_arbiter #(.GAP_CYCLES(16'(G)), .BUSY_TO(16'(BT))) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .TxD_start(TxD_start), .TxD_data(TxD_data), .TxD_busy(TxD_busy),
        .frame_active(frame_active), .grant(grant), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model
    initial begin
        TxD_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (TxD_start && uart_mode == 0) begin
                repeat (3) @(posedge clk);
                #1 TxD_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1 TxD_busy = 1'b0;
                last_fall = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic void push_frame(input bit ch, input logic [47:0] d0, input logic [31:0] d1);
        exp_q.push_back(ch ? 8'hA1 : 8'hA0);
        if (!ch) for (int i = 5; i >= 0; i--) exp_q.push_back(d0[i*8 +: 8]);
        else     for (int i = 3; i >= 0; i--) exp_q.push_back(d1[i*8 +: 8]);
        exp_q.push_back(8'hFF);
    endfunction

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) tick();
        vectors++;
        if ({TxD_start, TxD_data, ack0, ack1, frame_active, grant, err_timeout} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got start=%b data=%h ack=%b%b fa=%b grant=%b err=%b, expected 0 00 00 0 1 0",
                     TxD_start, TxD_data, ack0, ack1, frame_active, grant, err_timeout);
        end
        rst = 1'b0;
        repeat (5) tick();
        vectors++;
        if (TxD_start !== 1'b0 || frame_active !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet got start=%b fa=%b ack=%b%b, expected all 0", TxD_start, frame_active, ack0, ack1);
        end
    endtask

    task automatic test_single_ch0();
        int t_req, t_ack, t_first, n_ack;
        logic [7:0] exp;
        exp_q.delete();
        push_frame(1'b0, 48'h123456_ABCDEF, 32'h0);
        data0 = 48'h123456_ABCDEF; req0 = 1'b1; t_req = cyc;
        n_ack = 0; t_ack = -1; t_first = -1;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack0) begin n_ack++; t_ack = cyc; req0 = 1'b0; end
            if (TxD_start) begin
                if (t_first < 0) begin t_first = cyc; data0 = 48'hFFFF_0000_5555; end
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL ch0_byte got %h expected %h at cycle %0d", TxD_data, exp, cyc);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || frame_active !== 1'b0) begin
            miscompares++;
            $display("FAIL ch0_complete got %0d bytes outstanding fa=%b, expected 0 and 0", exp_q.size(), frame_active);
        end
        vectors++;
        if (n_ack != 1 || t_ack != t_req + 1 || t_first != t_req + 2) begin
            miscompares++;
            $display("FAIL ch0_latency got acks=%0d ack@+%0d start@+%0d, expected 1 +1 +2", n_ack, t_ack - t_req, t_first - t_req);
        end
        vectors++;
        if (cyc - last_fall != G + 3) begin
            miscompares++;
            $display("FAIL ch0_fa_drop got %0d cycles after busy fall, expected %0d", cyc - last_fall, G + 3);
        end
        repeat (10) begin
            tick();
            vectors++;
            if (ack0 !== 1'b0 || TxD_start !== 1'b0) begin
                miscompares++;
                $display("FAIL ch0_no_repeat got ack0=%b start=%b, expected 0 0", ack0, TxD_start);
            end
        end
    endtask

    task automatic test_single_ch1();
        int n_ack;
        logic [7:0] exp;
        exp_q.delete();
        push_frame(1'b1, 48'h0, 32'h0102_FFFE);
        data1 = 32'h0102_FFFE; req1 = 1'b1; n_ack = 0;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack0) n_ack += 100;
            if (ack1) begin n_ack++; req1 = 1'b0; end
            if (TxD_start) begin
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL ch1_byte got %h expected %h at cycle %0d", TxD_data, exp, cyc);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || n_ack != 1) begin
            miscompares++;
            $display("FAIL ch1_complete got outstanding=%0d ackcode=%0d, expected 0 and 1", exp_q.size(), n_ack);
        end
    endtask

    task automatic test_back_to_back();
        int n_both, n_ack;
        logic [3:0] seq;
        logic [7:0] exp;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        exp_q.delete();
        push_frame(1'b0, 48'h0A0B0C_0D0E0F, 32'h0);
        push_frame(1'b1, 48'h0, 32'h1111_2222);
        data0 = 48'h0A0B0C_0D0E0F; data1 = 32'h1111_2222;
        req0 = 1'b1; req1 = 1'b1;
        n_both = 0; n_ack = 0; seq = '0;
        for (int i = 0; i < 6000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack0 && ack1) n_both++;
            if (ack0) begin req0 = 1'b0; if (n_ack < 4) seq[n_ack] = 1'b0; n_ack++; end
            if (ack1) begin req1 = 1'b0; if (n_ack < 4) seq[n_ack] = 1'b1; n_ack++; end
            if (TxD_start) begin
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL tie_byte got %h expected %h at cycle %0d", TxD_data, exp, cyc);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || n_both != 0 || n_ack != 2 || seq[1:0] !== 2'b10) begin
            miscompares++;
            $display("FAIL tie_order got outstanding=%0d both=%0d acks=%0d seq=%b, expected 0 0 2 10", exp_q.size(), n_both, n_ack, seq[1:0]);
        end
        // Both held continuously: four frames alternating 0,1,0,1
        push_frame(1'b0, 48'h0A0B0C_0D0E0F, 32'h0);
        push_frame(1'b1, 48'h0, 32'h1111_2222);
        push_frame(1'b0, 48'h0A0B0C_0D0E0F, 32'h0);
        push_frame(1'b1, 48'h0, 32'h1111_2222);
        req0 = 1'b1; req1 = 1'b1; n_ack = 0; seq = '0;
        for (int i = 0; i < 12000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack0 && ack1) n_both++;
            if (ack0) begin if (n_ack < 4) seq[n_ack] = 1'b0; n_ack++; end
            if (ack1) begin if (n_ack < 4) seq[n_ack] = 1'b1; n_ack++; end
            if (n_ack >= 4) begin req0 = 1'b0; req1 = 1'b0; end
            if (TxD_start) begin
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL alt_byte got %h expected %h at cycle %0d", TxD_data, exp, cyc);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || n_both != 0 || n_ack != 4 || seq !== 4'b1010) begin
            miscompares++;
            $display("FAIL alt_order got outstanding=%0d both=%0d acks=%0d seq(lsb first)=%b, expected 0 0 4 1010", exp_q.size(), n_both, n_ack, seq);
        end
    endtask

    task automatic test_gap();
        int n_start, prev_start;
        logic [7:0] exp;
        exp_q.delete();
        push_frame(1'b1, 48'h0, 32'hC3C3_3C3C);
        data1 = 32'hC3C3_3C3C; req1 = 1'b1; n_start = 0; prev_start = -10;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack1) req1 = 1'b0;
            if (TxD_start) begin
                vectors++;
                if (cyc == prev_start + 1) begin
                    miscompares++;
                    $display("FAIL gap_consecutive_start got starts at %0d and %0d, expected non-adjacent", prev_start, cyc);
                end
                if (n_start > 0) begin
                    vectors++;
                    if (cyc - last_fall != G + 3) begin
                        miscompares++;
                        $display("FAIL gap_spacing got %0d cycles busy-fall to start, expected %0d", cyc - last_fall, G + 3);
                    end
                end
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL gap_byte got %h expected %h", TxD_data, exp);
                end
                prev_start = cyc;
                n_start++;
            end
        end
        vectors++;
        if (n_start != 6) begin
            miscompares++;
            $display("FAIL gap_count got %0d starts, expected 6", n_start);
        end
    endtask

    task automatic test_timeout();
        int n_start, prev_start, t_first, err_rise;
        logic [7:0] exp;
        uart_mode = 1;
        exp_q.delete();
        push_frame(1'b0, 48'h00FF00_FF00FF, 32'h0);
        data0 = 48'h00FF00_FF00FF; req0 = 1'b1;
        n_start = 0; prev_start = -1; t_first = -1; err_rise = -1;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack0) req0 = 1'b0;
            if (err_timeout === 1'b1 && err_rise < 0) err_rise = cyc;
            if (TxD_start) begin
                if (t_first < 0) begin
                    t_first = cyc;
                    vectors++;
                    if (err_timeout !== 1'b0) begin
                        miscompares++;
                        $display("FAIL to_err_early got err=%b at first start, expected 0", err_timeout);
                    end
                end
                if (prev_start >= 0) begin
                    vectors++;
                    if (cyc - prev_start != BT + G + 1) begin
                        miscompares++;
                        $display("FAIL to_spacing got %0d, expected %0d", cyc - prev_start, BT + G + 1);
                    end
                end
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL to_byte got %h expected %h", TxD_data, exp);
                end
                prev_start = cyc;
                n_start++;
            end
        end
        vectors++;
        if (n_start != 8 || err_rise < t_first + BT || err_rise > t_first + BT + 1 || err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL to_err got starts=%0d rise@+%0d err=%b, expected 8 +%0d..+%0d 1",
                     n_start, err_rise - t_first, err_timeout, BT, BT + 1);
        end
        uart_mode = 0;
    endtask

    task automatic test_rst_midframe();
        int n_start, n_ack, n_bad;
        logic [7:0] exp;
        exp_q.delete();
        push_frame(1'b0, 48'h123456_ABCDEF, 32'h0);
        data0 = 48'h123456_ABCDEF; req0 = 1'b1; n_start = 0;
        for (int i = 0; i < 2000 && n_start < 3; i++) begin
            tick();
            if (TxD_start) begin
                n_start++;
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL rst_pre_byte got %h expected %h", TxD_data, exp);
                end
            end
        end
        repeat (5) tick();
        vectors++;
        if (n_start != 3 || frame_active !== 1'b1 || err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_state got starts=%0d fa=%b err=%b, expected 3 1 1", n_start, frame_active, err_timeout);
        end
        rst = 1'b1; #1;
        vectors++;
        if ({TxD_start, TxD_data, frame_active, err_timeout, grant, ack0, ack1} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_async got start=%b data=%h fa=%b err=%b grant=%b ack=%b%b, expected 0 00 0 0 1 00",
                     TxD_start, TxD_data, frame_active, err_timeout, grant, ack0, ack1);
        end
        n_bad = 0;
        for (int i = 0; i < 200 && TxD_busy; i++) begin
            tick();
            if (TxD_start || ack0 || ack1) n_bad++;
        end
        tick();
        vectors++;
        if (TxD_busy !== 1'b0 || n_bad != 0) begin
            miscompares++;
            $display("FAIL rst_hold got busy=%b activity=%0d, expected 0 0", TxD_busy, n_bad);
        end
        rst = 1'b0;
        exp_q.delete();
        push_frame(1'b0, 48'h123456_ABCDEF, 32'h0);
        n_ack = 0;
        for (int i = 0; i < 3000 && (exp_q.size() != 0 || frame_active); i++) begin
            tick();
            if (ack0) begin n_ack++; req0 = 1'b0; end
            if (TxD_start) begin
                exp = 8'hxx;
                if (exp_q.size() != 0) exp = exp_q.pop_front();
                vectors++;
                if (TxD_data !== exp) begin
                    miscompares++;
                    $display("FAIL rst_restart_byte got %h expected %h", TxD_data, exp);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || n_ack != 1) begin
            miscompares++;
            $display("FAIL rst_restart got outstanding=%0d acks=%0d, expected 0 1", exp_q.size(), n_ack);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_ch0();
        test_single_ch1();
        test_back_to_back();
        test_gap();
        test_timeout();
        test_rst_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
